// File: rtl/bus8088_pkg.sv
// Shared types for the 8088-style bus master: one-hot bus state and the
// latched request that is carried through a bus cycle.
package bus8088_pkg;

    localparam int BUS_ADDR_W = 20;
    localparam int BUS_DATA_W = 8;

    typedef enum logic [5:0] {
        TI = 6'b000001,
        T1 = 6'b000010,
        T2 = 6'b000100,
        T3 = 6'b001000,
        TW = 6'b010000,
        T4 = 6'b100000
    } bus_state_t;

    typedef struct packed {
        logic                  write;
        logic                  io;
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] wdata;
    } bus_req_t;

    // Strobe phase: rd/wr and den are asserted from T2 through the last Tw.
    function automatic logic is_strobe(bus_state_t s);
        return (s == T2) || (s == T3) || (s == TW);
    endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Saturating wait-state counter with a terminal flag for the Tw timeout.
// count holds the number of Tw cycles already completed.
module bus_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != CNT_W'(WAIT_MAX))) begin
            count <= count + CNT_W'(1);
        end
    end

    // The current Tw is the WAIT_MAX-th one once WAIT_MAX-1 are behind us.
    assign last = (count >= CNT_W'(WAIT_MAX - 1));

endmodule

// File: rtl/bus_cycle_gen_8088.sv
// 8088-style bus master: turns single-byte valid/ready requests into
// T1-T2-T3-(Tw)-T4 bus cycles and returns one response per request.
module bus_cycle_gen_8088
    import bus8088_pkg::*;
#(
    parameter int ADDR_W   = BUS_ADDR_W,
    parameter int DATA_W   = BUS_DATA_W,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_io,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    input  logic              ready,
    output logic              ALE,
    output logic              IOM,
    output logic              rd,
    output logic              wr,
    output logic              den,
    output logic              dtr,
    output logic [ADDR_W-1:0] addr,
    inout  wire  [DATA_W-1:0] data
);

    bus_state_t state_q, state_d;
    bus_req_t   req_q;

    logic              accept;
    logic              capture;
    logic              timeout;
    logic              cnt_clr;
    logic              cnt_en;
    logic              cnt_last;
    logic              data_oe;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_err_q;

    bus_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .last  (cnt_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= TI;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        capture   = 1'b0;
        timeout   = 1'b0;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;

        unique case (state_q)
            TI: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = T1;
                end
            end
            T1: state_d = T2;
            T2: state_d = T3;
            T3: begin
                if (ready) begin
                    capture = 1'b1;
                    state_d = T4;
                end else begin
                    cnt_clr = 1'b1;
                    state_d = TW;
                end
            end
            TW: begin
                cnt_en = 1'b1;
                if (ready) begin
                    capture = 1'b1;
                    state_d = T4;
                end else if (cnt_last) begin
                    timeout = 1'b1;
                    state_d = T4;
                end
            end
            T4: state_d = TI;
            default: state_d = TI;
        endcase
    end

    // Bus pins decode straight from the state so reset releases them at once.
    always_comb begin
        req_ready = (state_q == TI);
        rsp_valid = (state_q == T4);
        ALE       = (state_q == T1);
        IOM       = 1'b0;
        dtr       = 1'b0;
        addr      = '0;
        rd        = 1'b1;
        wr        = 1'b1;
        den       = 1'b1;
        data_oe   = 1'b0;

        if (state_q != TI) begin
            IOM  = req_q.io;
            dtr  = req_q.write;
            addr = ADDR_W'(req_q.addr);
        end
        if (is_strobe(state_q)) begin
            den     = 1'b0;
            rd      = req_q.write;
            wr      = ~req_q.write;
            data_oe = req_q.write;
        end
    end

    assign data = data_oe ? DATA_W'(req_q.wdata) : 'z;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            if (accept) begin
                req_q      <= '{write: req_write,
                                io:    req_io,
                                addr:  BUS_ADDR_W'(req_addr),
                                wdata: BUS_DATA_W'(req_wdata)};
                rsp_data_q <= '0;
                rsp_err_q  <= 1'b0;
            end
            if (capture && !req_q.write) begin
                rsp_data_q <= data;
            end
            // A timed-out read reports all-ones; a timed-out write still reports 0.
            if (timeout) begin
                rsp_err_q  <= 1'b1;
                rsp_data_q <= req_q.write ? '0 : '1;
            end
        end
    end

    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_bus_cycle_gen_8088.sv
// Directed bench for bus_cycle_gen_8088: a byte-wide slave memory answers
// reads, and a bus keeper parks the data lines at 8'h3C when nobody strobes.
module tb_bus_cycle_gen_8088;

    localparam int    ADDR_W   = 20;
    localparam int    DATA_W   = 8;
    localparam int    WAIT_MAX = 15;
    localparam logic [7:0] PARK = 8'h3C;
    localparam int    BOUND    = 100;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_io;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              ready;
    logic              ALE;
    logic              IOM;
    logic              rd;
    logic              wr;
    logic              den;
    logic              dtr;
    logic [ADDR_W-1:0] addr;
    wire  [DATA_W-1:0] data;

    logic [7:0] mem [256];

    int checks   = 0;
    int failures = 0;

    // Results gathered by run_txn for the caller to check.
    int         cyc, ale_n, rd_n, wr_n, rdy_n, addr_bad, iom_bad, dtr_bad, bus_bad;
    logic [7:0] got_data;
    logic       got_err;
    logic       t4_ok;

    always #5 clk = ~clk;

    bus_cycle_gen_8088 #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .WAIT_MAX (WAIT_MAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_io    (req_io),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .ready     (ready),
        .ALE       (ALE),
        .IOM       (IOM),
        .rd        (rd),
        .wr        (wr),
        .den       (den),
        .dtr       (dtr),
        .addr      (addr),
        .data      (data)
    );

    assign data = !rd ? mem[addr[7:0]] : (den ? PARK : 8'hzz);

    always @(posedge clk) begin
        if (reset) begin
            mem[8'h03] <= 8'h5A;
            mem[8'h00] <= 8'hC3;
        end else if (!wr) begin
            mem[addr[7:0]] <= data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a TI negedge; returns at the negedge after T4 (back in TI).
    // lo = number of T3/Tw cycles that see ready=0.
    task automatic run_txn(input logic w, input logic io, input logic [19:0] a,
                           input logic [7:0] wd, input int lo, input logic keep_valid);
        int seen;
        seen = 0;
        ale_n = 0; rd_n = 0; wr_n = 0; rdy_n = 0;
        addr_bad = 0; iom_bad = 0; dtr_bad = 0; bus_bad = 0;
        req_valid = 1'b1; req_write = w; req_io = io; req_addr = a; req_wdata = wd;
        ready = 1'b0;
        @(negedge clk);
        cyc = 2;
        req_valid = keep_valid;
        req_write = ~w; req_io = ~io; req_addr = ~a; req_wdata = ~wd;
        while (!rsp_valid && cyc < BOUND) begin
            ale_n += int'(ALE);
            if (!rd) rd_n++;
            if (!wr) wr_n++;
            if (req_ready) rdy_n++;
            if (addr !== a) addr_bad++;
            if (IOM !== io) iom_bad++;
            if (dtr !== w) dtr_bad++;
            if (den) begin
                if (data !== PARK) bus_bad++;
            end else if (w && data !== wd) begin
                bus_bad++;
            end
            if (!den) seen++;
            ready = (seen > 1 + lo);
            @(negedge clk);
            cyc++;
        end
        t4_ok    = rd && wr && den && (data === PARK) && (addr === a) && (IOM === io) && !req_ready;
        got_data = rsp_data;
        got_err  = rsp_err;
        ready    = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        check("after_t4_rsp_valid", 32'(rsp_valid), 32'd0);
        check("after_t4_req_ready", 32'(req_ready), 32'd1);
        check("after_t4_addr", 32'(addr), 32'd0);
    endtask

    initial begin
        int pulses;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_io = 1'b0;
        req_addr = '0; req_wdata = '0; ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_strobes", {29'd0, rd, wr, den}, 32'h7);
        check("rst_ale_iom_dtr", {29'd0, ALE, IOM, dtr}, 32'h0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_rsp", {23'd0, rsp_valid, rsp_err, rsp_data}, 32'd0);
        check("rst_data_z", 32'(data), 32'(PARK));
        reset = 1'b0;
        @(negedge clk);
        check("idle_req_ready", 32'(req_ready), 32'd1);

        // IO read 0xFF03, zero wait states
        run_txn(1'b0, 1'b1, 20'hFF03, 8'h00, 0, 1'b0);
        check("rd_cycles", 32'(cyc), 32'd5);
        check("rd_ale", 32'(ale_n), 32'd1);
        check("rd_rd_low", 32'(rd_n), 32'd2);
        check("rd_wr_low", 32'(wr_n), 32'd0);
        check("rd_data", 32'(got_data), 32'h5A);
        check("rd_err", 32'(got_err), 32'd0);
        check("rd_pins", 32'(addr_bad + iom_bad + dtr_bad + bus_bad + rdy_n), 32'd0);
        check("rd_t4", 32'(t4_ok), 32'd1);

        // IO write 0x1C10 <- 0xA5
        run_txn(1'b1, 1'b1, 20'h1C10, 8'hA5, 0, 1'b0);
        check("wr_cycles", 32'(cyc), 32'd5);
        check("wr_wr_low", 32'(wr_n), 32'd2);
        check("wr_rd_low", 32'(rd_n), 32'd0);
        check("wr_bus", 32'(bus_bad), 32'd0);
        check("wr_pins", 32'(addr_bad + iom_bad + dtr_bad + rdy_n), 32'd0);
        check("wr_rsp", {23'd0, got_err, got_data}, 32'd0);
        check("wr_t4", 32'(t4_ok), 32'd1);

        // Read with two wait states
        run_txn(1'b0, 1'b1, 20'hFF03, 8'h00, 2, 1'b0);
        check("wait2_cycles", 32'(cyc), 32'd7);
        check("wait2_rd_low", 32'(rd_n), 32'd4);
        check("wait2_data", 32'(got_data), 32'h5A);
        check("wait2_err", 32'(got_err), 32'd0);

        // ready stuck low on a read: WAIT_MAX Tw cycles then abort
        run_txn(1'b0, 1'b1, 20'hFF03, 8'h00, 255, 1'b0);
        check("tmo_rd_cycles", 32'(cyc), 32'(5 + WAIT_MAX));
        check("tmo_rd_rd_low", 32'(rd_n), 32'(2 + WAIT_MAX));
        check("tmo_rd_data", 32'(got_data), 32'hFF);
        check("tmo_rd_err", 32'(got_err), 32'd1);
        check("tmo_rd_t4", 32'(t4_ok), 32'd1);

        // ready stuck low on a write: error flagged, data reported as 0
        run_txn(1'b1, 1'b1, 20'h1C20, 8'h11, 255, 1'b0);
        check("tmo_wr_cycles", 32'(cyc), 32'(5 + WAIT_MAX));
        check("tmo_wr_rsp", {23'd0, got_err, got_data}, 32'h100);
        check("tmo_wr_bus", 32'(bus_bad), 32'd0);

        // Read back the earlier write; error must be clear again
        run_txn(1'b0, 1'b1, 20'h1C10, 8'h00, 0, 1'b0);
        check("rdback_data", 32'(got_data), 32'hA5);
        check("rdback_err", 32'(got_err), 32'd0);

        // Reset during T2 of a write
        req_valid = 1'b1; req_write = 1'b1; req_io = 1'b1;
        req_addr = 20'h1C10; req_wdata = 8'h77;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("abort_t2_strobes", {30'd0, wr, den}, 32'h0);
        check("abort_t2_data", 32'(data), 32'h77);
        #2 reset = 1'b1;
        #1;
        check("abort_strobes", {29'd0, rd, wr, den}, 32'h7);
        check("abort_data_z", 32'(data), 32'(PARK));
        check("abort_addr", 32'(addr), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        check("abort_no_rsp", 32'(pulses), 32'd0);
        run_txn(1'b0, 1'b1, 20'h1C10, 8'h00, 0, 1'b0);
        check("post_abort_cycles", 32'(cyc), 32'd5);
        check("post_abort_data", 32'(got_data), 32'hA5);

        // Memory read held valid, then an immediate back-to-back request
        run_txn(1'b0, 1'b0, 20'h00100, 8'h00, 0, 1'b1);
        check("mem_cycles", 32'(cyc), 32'd5);
        check("mem_iom", 32'(iom_bad), 32'd0);
        check("mem_req_ready_busy", 32'(rdy_n), 32'd0);
        check("mem_addr_held", 32'(addr_bad), 32'd0);
        check("mem_data", 32'(got_data), 32'hC3);
        run_txn(1'b0, 1'b1, 20'hFF03, 8'h00, 0, 1'b0);
        check("b2b_cycles", 32'(cyc), 32'd5);
        check("b2b_data", 32'(got_data), 32'h5A);
        check("b2b_pins", 32'(iom_bad + rdy_n + addr_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
